wt_dcache_mem_responder: RTL and testbench

// - Memory-side responder for the write-through dcache memory interface, i.e. the far end of the dcache request/return channel.
// - Accepts line-fill loads and byte-masked word stores. Returns fills and acks tagged with the request TID, in strict arrival order.
// - Stands in for the L2/NoC adapter in standalone dcache benches and bring-up. The backing store is an internal 64-bit word array.

---
 rtl/wt_dcache_mem_responder_if.sv | 32 +++
 rtl/wt_dcache_mem_responder.sv | 267 ++++++++++++++++++++++++++
 tb/tb_wt_dcache_mem_responder.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/wt_dcache_mem_responder_if.sv
// Request/return channel between the write-through dcache (master) and its memory-side responder (slave).
interface wt_dcache_mem_responder_if #(
   parameter int AddrWidth   = 64,
   parameter int LineWidth   = 128,
   parameter int MemTidWidth = 2
);
   logic                   req_valid_i;
   logic                   req_ready_o;
   logic [1:0]             req_type_i;
   logic [MemTidWidth-1:0] req_tid_i;
   logic [AddrWidth-1:0]   req_addr_i;
   logic [63:0]            req_wdata_i;
   logic [7:0]             req_be_i;
   logic [1:0]             req_amo_op_i;
   logic                   rtrn_valid_o;
   logic                   rtrn_ready_i;
   logic [1:0]             rtrn_type_o;
   logic [MemTidWidth-1:0] rtrn_tid_o;
   logic [LineWidth-1:0]   rtrn_data_o;

   modport master (
      output req_valid_i, req_type_i, req_tid_i, req_addr_i, req_wdata_i, req_be_i, req_amo_op_i,
      output rtrn_ready_i,
      input  req_ready_o, rtrn_valid_o, rtrn_type_o, rtrn_tid_o, rtrn_data_o
   );

   modport slave (
      input  req_valid_i, req_type_i, req_tid_i, req_addr_i, req_wdata_i, req_be_i, req_amo_op_i,
      input  rtrn_ready_i,
      output req_ready_o, rtrn_valid_o, rtrn_type_o, rtrn_tid_o, rtrn_data_o
   );
endinterface

// File: rtl/wt_dcache_mem_responder.sv
// Memory-side responder for the WT dcache: in-order request FIFO, fixed-latency access to a 64-bit word array.
// Optional AMO support is enabled by defining WT_DCACHE_MEM_RESP_AMO_EN (otherwise AMO returns ERROR).
module wt_dcache_mem_responder #(
   parameter int AddrWidth    = 64,
   parameter int LineWidth    = 128,
   parameter int MemTidWidth  = 2,
   parameter int MemWords     = 1024,
   parameter int ReqFifoDepth = 8,
   parameter int Latency      = 2
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   wt_dcache_mem_responder_if.slave mem_if,
   output logic                     busy_o
);

   localparam int IdxW      = $clog2(MemWords);
   localparam int PtrW      = $clog2(ReqFifoDepth);
   localparam int CntW      = $clog2(ReqFifoDepth + 1);
   localparam int LatW      = (Latency > 1) ? $clog2(Latency) : 1;
   localparam int LineWords = LineWidth / 64;

   localparam logic [1:0] REQ_LOAD  = 2'b00;
   localparam logic [1:0] REQ_STORE = 2'b01;
   localparam logic [1:0] REQ_AMO   = 2'b10;

   localparam logic [1:0] RTRN_LOAD_ACK  = 2'b00;
   localparam logic [1:0] RTRN_STORE_ACK = 2'b01;
   localparam logic [1:0] RTRN_AMO_ACK   = 2'b10;
   localparam logic [1:0] RTRN_ERROR     = 2'b11;

   localparam logic [PtrW:0]   PTR_ONE   = (PtrW + 1)'(1);
   localparam logic [CntW-1:0] CNT_ONE   = CntW'(1);
   localparam logic [CntW-1:0] CNT_FULL  = CntW'(ReqFifoDepth);
   localparam logic [IdxW-1:0] LINE_MASK = ~IdxW'(LineWords - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

   typedef struct packed {
`ifdef WT_DCACHE_MEM_RESP_AMO_EN
      logic [1:0]             amo_op;
`endif
      logic [1:0]             typ;
      logic [MemTidWidth-1:0] tid;
      logic [IdxW-1:0]        idx;
      logic [63:0]            wdata;
      logic [7:0]             be;
   } req_t;

   function automatic logic [63:0] f_byte_merge(input logic [63:0] old_w, input logic [63:0] new_w,
                                                input logic [7:0] be);
      logic [63:0] res;
      res = old_w;
      for (int b = 0; b < 8; b++) begin
         if (be[b]) res[8*b +: 8] = new_w[8*b +: 8];
      end
      return res;
   endfunction

`ifdef WT_DCACHE_MEM_RESP_AMO_EN
   function automatic logic [63:0] f_amo(input logic [1:0] op, input logic [63:0] old_w,
                                         input logic [63:0] opnd);
      logic [63:0] res;
      case (op)
         2'b00:   res = opnd;
         2'b01:   res = old_w + opnd;
         2'b10:   res = old_w & opnd;
         2'b11:   res = old_w | opnd;
         default: res = opnd;
      endcase
      return res;
   endfunction
`endif

   logic [63:0]          r_mem [MemWords];
   req_t                 r_fifo [ReqFifoDepth];
   logic [PtrW:0]        r_wptr, r_wptr_q, r_rptr;
   logic [CntW-1:0]      r_cnt;
   logic                 r_req_ready;
   state_t               r_state;
   logic [LatW-1:0]      r_lat_cnt;
   req_t                 r_hold;
   logic                 r_rtrn_valid;
   logic [1:0]           r_rtrn_type;
   logic [MemTidWidth-1:0] r_rtrn_tid;
   logic [LineWidth-1:0] r_rtrn_data;
   logic                 r_busy;

   req_t                 w_req;
   logic                 w_push, w_pop, w_rd_avail, w_access;
   logic [CntW-1:0]      w_cnt_nxt;
   logic                 w_fsm_busy_nxt;
   logic [63:0]          w_word_old, w_mem_wdata;
   logic [IdxW-1:0]      w_line_base;
   logic                 w_mem_we;
   logic [1:0]           w_rsp_type;
   logic [LineWidth-1:0] w_rsp_data;
   logic                 w_unused;

   // Address bits outside the word index are ignored, so the array wraps around.
`ifdef WT_DCACHE_MEM_RESP_AMO_EN
   assign w_unused = ^{mem_if.req_addr_i[AddrWidth-1:3+IdxW], mem_if.req_addr_i[2:0]};
`else
   assign w_unused = ^{mem_if.req_addr_i[AddrWidth-1:3+IdxW], mem_if.req_addr_i[2:0],
                       mem_if.req_amo_op_i};
`endif

   // The FSM only sees entries through a delayed write pointer, adding one cycle of first-word latency.
   assign w_push     = mem_if.req_valid_i && r_req_ready;
   assign w_rd_avail = (r_rptr != r_wptr_q);
   assign w_pop      = (r_state == ST_IDLE) && w_rd_avail;
   assign w_access   = (r_state == ST_WAIT) && (r_lat_cnt == '0);

   // Pack the incoming request into a queue entry.
   always_comb begin
      w_req       = '0;
      w_req.typ   = mem_if.req_type_i;
      w_req.tid   = mem_if.req_tid_i;
      w_req.idx   = mem_if.req_addr_i[3 +: IdxW];
      w_req.wdata = mem_if.req_wdata_i;
      w_req.be    = mem_if.req_be_i;
`ifdef WT_DCACHE_MEM_RESP_AMO_EN
      w_req.amo_op = mem_if.req_amo_op_i;
`endif
   end

   // Next queue occupancy.
   always_comb begin
      w_cnt_nxt = r_cnt;
      if (w_push && !w_pop) begin
         w_cnt_nxt = r_cnt + CNT_ONE;
      end else if (!w_push && w_pop) begin
         w_cnt_nxt = r_cnt - CNT_ONE;
      end else begin
         w_cnt_nxt = r_cnt;
      end
   end

   // Whether the FSM will be outside IDLE after this edge.
   always_comb begin
      w_fsm_busy_nxt = 1'b0;
      case (r_state)
         ST_IDLE: w_fsm_busy_nxt = w_rd_avail;
         ST_WAIT: w_fsm_busy_nxt = 1'b1;
         ST_RESP: w_fsm_busy_nxt = !mem_if.rtrn_ready_i;
         default: w_fsm_busy_nxt = 1'b0;
      endcase
   end

   // Queue entry storage (not reset).
   always_ff @(posedge clk_i) begin
      if (w_push) r_fifo[r_wptr[PtrW-1:0]] <= w_req;
   end

   // Queue pointers, occupancy, registered ready and busy.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_wptr      <= '0;
         r_wptr_q    <= '0;
         r_rptr      <= '0;
         r_cnt       <= '0;
         r_req_ready <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         if (w_push) r_wptr <= r_wptr + PTR_ONE;
         if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
         r_wptr_q    <= r_wptr;
         r_cnt       <= w_cnt_nxt;
         r_req_ready <= (w_cnt_nxt != CNT_FULL);
         r_busy      <= (w_cnt_nxt != '0) || w_fsm_busy_nxt;
      end
   end

   // Response and array-update computation for the held request.
   always_comb begin
      w_word_old  = r_mem[r_hold.idx];
      w_line_base = r_hold.idx & LINE_MASK;
      w_rsp_type  = RTRN_ERROR;
      w_rsp_data  = '0;
      w_mem_we    = 1'b0;
      w_mem_wdata = w_word_old;
      case (r_hold.typ)
         REQ_LOAD: begin
            w_rsp_type = RTRN_LOAD_ACK;
            for (int k = 0; k < LineWords; k++) begin
               w_rsp_data[64*k +: 64] = r_mem[w_line_base + IdxW'(k)];
            end
         end
         REQ_STORE: begin
            w_rsp_type  = RTRN_STORE_ACK;
            w_mem_we    = 1'b1;
            w_mem_wdata = f_byte_merge(w_word_old, r_hold.wdata, r_hold.be);
         end
`ifdef WT_DCACHE_MEM_RESP_AMO_EN
         REQ_AMO: begin
            w_rsp_type       = RTRN_AMO_ACK;
            w_rsp_data[63:0] = w_word_old;
            w_mem_we         = 1'b1;
            w_mem_wdata      = f_byte_merge(w_word_old,
                                            f_amo(r_hold.amo_op, w_word_old, r_hold.wdata),
                                            r_hold.be);
         end
`endif
         default: begin
            w_rsp_type = RTRN_ERROR;
            w_rsp_data = '0;
         end
      endcase
   end

   // Backing array write, only at the WAIT->RESP transition.
   always_ff @(posedge clk_i) begin
      if (!rst_i && w_access && w_mem_we) r_mem[r_hold.idx] <= w_mem_wdata;
   end

   // Control FSM with registered return channel.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state      <= ST_IDLE;
         r_lat_cnt    <= '0;
         r_hold       <= '0;
         r_rtrn_valid <= 1'b0;
         r_rtrn_type  <= 2'b00;
         r_rtrn_tid   <= '0;
         r_rtrn_data  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_rd_avail) begin
                  r_hold    <= r_fifo[r_rptr[PtrW-1:0]];
                  r_lat_cnt <= LatW'(Latency - 1);
                  r_state   <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (r_lat_cnt != '0) begin
                  r_lat_cnt <= r_lat_cnt - LatW'(1);
               end else begin
                  r_rtrn_valid <= 1'b1;
                  r_rtrn_type  <= w_rsp_type;
                  r_rtrn_tid   <= r_hold.tid;
                  r_rtrn_data  <= w_rsp_data;
                  r_state      <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (mem_if.rtrn_ready_i) begin
                  r_rtrn_valid <= 1'b0;
                  r_state      <= ST_IDLE;
               end
            end
            default: begin
               r_rtrn_valid <= 1'b0;
               r_state      <= ST_IDLE;
            end
         endcase
      end
   end

   assign mem_if.req_ready_o  = r_req_ready;
   assign mem_if.rtrn_valid_o = r_rtrn_valid;
   assign mem_if.rtrn_type_o  = r_rtrn_type;
   assign mem_if.rtrn_tid_o   = r_rtrn_tid;
   assign mem_if.rtrn_data_o  = r_rtrn_data;
   assign busy_o              = r_busy;

endmodule

// File: tb/tb_wt_dcache_mem_responder.sv
// Scoreboard bench for wt_dcache_mem_responder (Latency=3); AMO expectations follow WT_DCACHE_MEM_RESP_AMO_EN.
module tb_wt_dcache_mem_responder;

   localparam int LAT       = 3;
   localparam int MEM_WORDS = 1024;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic busy;

   wt_dcache_mem_responder_if #(.AddrWidth(64), .LineWidth(128), .MemTidWidth(2)) mem_if ();

   wt_dcache_mem_responder #(
      .AddrWidth(64), .LineWidth(128), .MemTidWidth(2),
      .MemWords(MEM_WORDS), .ReqFifoDepth(8), .Latency(LAT)
   ) dut (
      .clk_i  (clk),
      .rst_i  (rst),
      .mem_if (mem_if),
      .busy_o (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]   typ;
      logic [1:0]   tid;
      logic [127:0] data;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        mon_e;
   logic [63:0] mdl [int];
   int          n_cmp = 0;
   int          n_err = 0;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] rd_word(input int idx);
      return mdl.exists(idx) ? mdl[idx] : 64'h0;
   endfunction

   function automatic logic [63:0] merge_be(input logic [63:0] o, input logic [63:0] n, input logic [7:0] be);
      logic [63:0] r;
      r = o;
      for (int b = 0; b < 8; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
      return r;
   endfunction

   task automatic send(input logic [1:0] typ, input logic [1:0] tid, input logic [63:0] addr,
                       input logic [63:0] wd, input logic [7:0] be, input logic [1:0] op,
                       input bit track, input int max_wait, output bit ok);
      exp_t        e;
      int          idx, base;
      logic [63:0] old, res;
      mem_if.req_type_i   = typ;
      mem_if.req_tid_i    = tid;
      mem_if.req_addr_i   = addr;
      mem_if.req_wdata_i  = wd;
      mem_if.req_be_i     = be;
      mem_if.req_amo_op_i = op;
      mem_if.req_valid_i  = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < max_wait && !ok; i++) begin
         @(negedge clk);
         if (mem_if.req_ready_o) begin
            @(posedge clk);
            #1;
            ok = 1'b1;
         end
      end
      mem_if.req_valid_i = 1'b0;
      if (ok && track) begin
         idx    = int'((addr >> 3) & 64'(MEM_WORDS - 1));
         base   = idx & ~1;
         e.tid  = tid;
         e.data = '0;
         case (typ)
            2'b00: begin
               e.typ  = 2'b00;
               e.data = {rd_word(base + 1), rd_word(base)};
            end
            2'b01: begin
               e.typ    = 2'b01;
               mdl[idx] = merge_be(rd_word(idx), wd, be);
            end
            2'b10: begin
`ifdef WT_DCACHE_MEM_RESP_AMO_EN
               old = rd_word(idx);
               case (op)
                  2'b00:   res = wd;
                  2'b01:   res = old + wd;
                  2'b10:   res = old & wd;
                  default: res = old | wd;
               endcase
               mdl[idx] = merge_be(old, res, be);
               e.typ    = 2'b10;
               e.data   = {64'h0, old};
`else
               old    = 64'h0;
               res    = 64'h0;
               e.typ  = 2'b11;
`endif
            end
            default: e.typ = 2'b11;
         endcase
         sb_q.push_back(e);
      end
   endtask

   task automatic do_req(input logic [1:0] typ, input logic [1:0] tid, input logic [63:0] addr,
                         input logic [63:0] wd, input logic [7:0] be, input logic [1:0] op);
      bit ok;
      send(typ, tid, addr, wd, be, op, 1'b1, 200, ok);
      check_eq("req_accept", ok, 1'b1);
   endtask

   task automatic wait_drain(input int max_cyc);
      for (int i = 0; i < max_cyc && (sb_q.size() != 0 || busy); i++) @(posedge clk);
      #1;
      check_eq("drain_sb_empty", sb_q.size(), 32'd0);
      check_eq("drain_busy", busy, 1'b0);
   endtask

   // Return-channel monitor: compare each handshaken response against the scoreboard head.
   always @(negedge clk) begin
      if (!rst && mem_if.rtrn_valid_o && mem_if.rtrn_ready_i) begin
         check_eq("rtrn_expected", sb_q.size() != 0, 1'b1);
         if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            check_eq("rtrn_type", mem_if.rtrn_type_o, mon_e.typ);
            check_eq("rtrn_tid", mem_if.rtrn_tid_o, mon_e.tid);
            check_eq("rtrn_data", mem_if.rtrn_data_o, mon_e.data);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bit ok;
      int acc;
      int rise;
      mem_if.req_valid_i  = 1'b0;
      mem_if.req_type_i   = 2'b00;
      mem_if.req_tid_i    = 2'b00;
      mem_if.req_addr_i   = 64'h0;
      mem_if.req_wdata_i  = 64'h0;
      mem_if.req_be_i     = 8'h00;
      mem_if.req_amo_op_i = 2'b00;
      mem_if.rtrn_ready_i = 1'b1;

      // Reset
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_ready", mem_if.req_ready_o, 1'b0);
      check_eq("rst_valid", mem_if.rtrn_valid_o, 1'b0);
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_type", mem_if.rtrn_type_o, 2'b00);
      check_eq("rst_tid", mem_if.rtrn_tid_o, 2'b00);
      check_eq("rst_data", mem_if.rtrn_data_o, 128'h0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check_eq("post_rst_ready", mem_if.req_ready_o, 1'b1);

      // Preload every word the loads will touch
      do_req(2'b01, 2'd0, 64'h80,  64'hA0A0_0000_0000_0080, 8'hFF, 2'b00);
      do_req(2'b01, 2'd1, 64'h88,  64'hA1A1_0000_0000_0088, 8'hFF, 2'b00);
      do_req(2'b01, 2'd2, 64'h100, 64'hA2A2_0000_0000_0100, 8'hFF, 2'b00);
      do_req(2'b01, 2'd3, 64'h108, 64'hA3A3_0000_0000_0108, 8'hFF, 2'b00);

      // Store then load within the same line; partial-byte store
      do_req(2'b01, 2'd1, 64'h80, 64'h1122334455667788, 8'hFF, 2'b00);
      do_req(2'b00, 2'd2, 64'h88, 64'h0, 8'h00, 2'b00);
      do_req(2'b01, 2'd3, 64'h80, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 2'b00);
      do_req(2'b00, 2'd0, 64'h80, 64'h0, 8'h00, 2'b00);
      wait_drain(400);

      // Reserved type, zero byte-enable store, address wrap-around
      do_req(2'b11, 2'd1, 64'h80, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 2'b00);
      do_req(2'b01, 2'd2, 64'h88, 64'h5555_5555_5555_5555, 8'h00, 2'b00);
      do_req(2'b00, 2'd3, 64'h80, 64'h0, 8'h00, 2'b00);
      do_req(2'b01, 2'd0, 64'h80 + 64'(MEM_WORDS * 8), 64'h0F0E_0D0C_0B0A_0908, 8'hFF, 2'b00);
      do_req(2'b00, 2'd1, 64'h88, 64'h0, 8'h00, 2'b00);

      // AMO ADD on a word holding 5
      do_req(2'b01, 2'd2, 64'h80, 64'd5, 8'hFF, 2'b00);
      do_req(2'b10, 2'd3, 64'h80, 64'd3, 8'hFF, 2'b01);
      do_req(2'b00, 2'd0, 64'h80, 64'h0, 8'h00, 2'b00);
      wait_drain(600);

      // Backpressure: 10 requests offered, 9 fit (8 queued + 1 held)
      mem_if.rtrn_ready_i = 1'b0;
      acc = 0;
      for (int i = 0; i < 10; i++) begin
         send(2'b00, 2'(i % 4), (i % 2 == 1) ? 64'h100 : 64'h80, 64'h0, 8'h00, 2'b00, 1'b1, 20, ok);
         if (ok) acc++;
      end
      check_eq("bp_accepted", acc, 32'd9);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_eq("bp_ready_low", mem_if.req_ready_o, 1'b0);
         check_eq("bp_valid_held", mem_if.rtrn_valid_o, 1'b1);
         check_eq("bp_tid_stable", mem_if.rtrn_tid_o, sb_q[0].tid);
         check_eq("bp_data_stable", mem_if.rtrn_data_o, sb_q[0].data);
      end
      @(posedge clk);
      #1;
      mem_if.rtrn_ready_i = 1'b1;
      wait_drain(200);

      // Latency: valid rises after edge E0+LAT+2, holds under backpressure, drops after handshake
      mem_if.rtrn_ready_i = 1'b0;
      send(2'b00, 2'd2, 64'h108, 64'h0, 8'h00, 2'b00, 1'b1, 50, ok);
      check_eq("lat_accept", ok, 1'b1);
      rise = 0;
      for (int i = 1; i <= 20 && rise == 0; i++) begin
         @(posedge clk);
         #1;
         if (mem_if.rtrn_valid_o) rise = i;
      end
      check_eq("lat_rise_edge", rise, 32'(LAT + 2));
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check_eq("lat_hold", mem_if.rtrn_valid_o, 1'b1);
      end
      mem_if.rtrn_ready_i = 1'b1;
      @(posedge clk);
      #1;
      check_eq("lat_drop", mem_if.rtrn_valid_o, 1'b0);
      wait_drain(50);

      // Reset while a store to 0x100 is in WAIT: the store is lost
      send(2'b01, 2'd1, 64'h100, 64'h7777_7777_7777_7777, 8'hFF, 2'b00, 1'b0, 50, ok);
      check_eq("rstw_accept", ok, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      check_eq("rstw_busy", busy, 1'b1);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check_eq("rstw_no_rtrn", mem_if.rtrn_valid_o, 1'b0);
      check_eq("rstw_idle", busy, 1'b0);
      do_req(2'b00, 2'd3, 64'h100, 64'h0, 8'h00, 2'b00);
      wait_drain(100);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
